// File: rtl/reg_pair_checker.sv
// Run-based comparator for a DUT register output and its golden model: samples
// both for NUM_SAMPLES cycles, counts mismatches and captures the first one.
module reg_pair_checker #(
  parameter int W           = 8,
  parameter int NUM_SAMPLES = 17,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [W-1:0]     dut_out,
  input  logic [W-1:0]     ref_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [W-1:0]     first_fail_dut,
  output logic [W-1:0]     first_fail_ref,
  output logic [1:0]       dbg_state
);

  // The sample index must be able to reach NUM_SAMPLES-1 without wrapping.
  generate
    if (NUM_SAMPLES < 1 || (2 ** CNT_W) <= NUM_SAMPLES) begin : g_bad_params
      $error("reg_pair_checker: need NUM_SAMPLES >= 1 and 2**CNT_W > NUM_SAMPLES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic [W-1:0]     ff_dut_q;
  logic [W-1:0]     ff_ref_q;
  logic             seen_q;
  logic             busy_q;
  logic             done_q;

  logic             mismatch;
  logic             last_sample;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] fail_cnt_d;

  always_comb begin
    mismatch    = (dut_out != ref_out);
    last_sample = (idx_q == CNT_W'(NUM_SAMPLES - 1));
    idx_d       = idx_q + CNT_W'(1);
    fail_cnt_d  = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_dut_q   <= '0;
      ff_ref_q   <= '0;
      seen_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            idx_q      <= '0;
            fail_cnt_q <= '0;
            ff_idx_q   <= '0;
            ff_dut_q   <= '0;
            ff_ref_q   <= '0;
            seen_q     <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          idx_q <= idx_d;
          if (mismatch) begin
            fail_cnt_q <= fail_cnt_d;
            if (!seen_q) begin
              ff_idx_q <= idx_q;
              ff_dut_q <= dut_out;
              ff_ref_q <= ref_out;
              seen_q   <= 1'b1;
            end
          end
          // start is deliberately not looked at here: runs cannot be restarted.
          if (last_sample) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (fail_cnt_q == '0);
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_dut = ff_dut_q;
  assign first_fail_ref = ff_ref_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_reg_pair_checker.sv
// Directed bench for reg_pair_checker: a per-cycle run model plus hand-computed
// result checks, and a small-counter instance for the narrow-width case.
module tb_reg_pair_checker;

  localparam int NUM = 17;

  logic       clk;
  logic       res;
  logic       start;
  logic [7:0] dut_out;
  logic [7:0] ref_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_cnt;
  logic [7:0] first_fail_idx;
  logic [7:0] first_fail_dut;
  logic [7:0] first_fail_ref;
  logic [1:0] dbg_state;

  logic       start2;
  logic [7:0] dut2;
  logic [7:0] ref2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [1:0] fc2;
  logic [1:0] ffi2;
  logic [7:0] ffd2;
  logic [7:0] ffr2;
  logic [1:0] dbg2;

  int total = 0;
  int bad   = 0;

  reg_pair_checker #(.W(8), .NUM_SAMPLES(NUM), .CNT_W(8)) u_dut (
    .clk(clk), .res(res), .start(start), .dut_out(dut_out), .ref_out(ref_out),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_dut(first_fail_dut),
    .first_fail_ref(first_fail_ref), .dbg_state(dbg_state)
  );

  reg_pair_checker #(.W(8), .NUM_SAMPLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .res(res), .start(start2), .dut_out(dut2), .ref_out(ref2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fc2),
    .first_fail_idx(ffi2), .first_fail_dut(ffd2),
    .first_fail_ref(ffr2), .dbg_state(dbg2)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model records the sample pairs of the current run; every expected
  // output is derived from that list (mismatch count, first mismatch).
  logic [7:0] m_dut[$];
  logic [7:0] m_ref[$];
  int         m_phase = 0;   // 0 idle, 1 running, 2 results ready

  initial begin
    int cnt;
    int fidx;
    logic [7:0] fd;
    logic [7:0] fr;
    bit found;
    forever begin
      @(posedge clk);
      if (res) begin
        m_phase = 0;
        m_dut.delete();
        m_ref.delete();
      end else begin
        case (m_phase)
          0, 2: if (start) begin
            m_phase = 1;
            m_dut.delete();
            m_ref.delete();
          end
          default: begin
            m_dut.push_back(dut_out);
            m_ref.push_back(ref_out);
            if (m_dut.size() == NUM) m_phase = 2;
          end
        endcase
      end
      #1;
      cnt = 0; fidx = 0; fd = 8'h00; fr = 8'h00; found = 1'b0;
      foreach (m_dut[i]) begin
        if (m_dut[i] != m_ref[i]) begin
          cnt++;
          if (!found) begin
            found = 1'b1;
            fidx  = i;
            fd    = m_dut[i];
            fr    = m_ref[i];
          end
        end
      end
      if (cnt > 255) cnt = 255;
      chk("model_busy", 32'(busy), 32'(m_phase == 1));
      chk("model_done", 32'(done), 32'(m_phase == 2));
      chk("model_pass", 32'(pass), 32'(m_phase == 2 && cnt == 0));
      chk("model_fail_cnt", 32'(fail_cnt), 32'(cnt));
      chk("model_ff_idx", 32'(first_fail_idx), 32'(fidx));
      chk("model_ff_dut", 32'(first_fail_dut), 32'(fd));
      chk("model_ff_ref", 32'(first_fail_ref), 32'(fr));
    end
  end

  // ---------------- driver ----------------
  // One run: start pulse, then one sample per cycle. Sample k is the dut value
  // 'bad' when mask[k] is set, otherwise 'good'; ref is always 'good'.
  task automatic do_run(input logic [16:0] mask, input logic [7:0] good,
                        input logic [7:0] badv, input int start_at, input int abort_at);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      @(negedge clk);
      start = (k == start_at);
      if (k == 0) begin
        chk("run_entered_busy", 32'(busy), 32'd1);
        chk("run_entered_cleared", 32'(fail_cnt), 32'd0);
        chk("run_entered_ff_idx", 32'(first_fail_idx), 32'd0);
      end
      if (k == 16) chk("done_not_early", 32'(done), 32'd0);
      if (k == abort_at) begin
        res = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("abort_ff_idx", 32'(first_fail_idx), 32'd0);
        @(negedge clk);
        res   = 1'b0;
        start = 1'b0;
        return;
      end
      dut_out = mask[k] ? badv : good;
      ref_out = good;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_after_18_edges", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int i;
    logic [7:0] rv;
    res = 1'b1; start = 1'b0; dut_out = 8'h00; ref_out = 8'h00;
    start2 = 1'b0; dut2 = 8'h00; ref2 = 8'h00;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_ff", {first_fail_idx, first_fail_dut, first_fail_ref}, 32'd0);
    #3;
    res = 1'b0;

    // Clean run
    do_run(17'h00000, 8'h77, 8'h77, -1, -1);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("clean_ff", {first_fail_idx, first_fail_dut, first_fail_ref}, 32'd0);

    // Single mismatch at sample 4
    do_run(17'h00010, 8'h77, 8'h00, -1, -1);
    chk("single_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("single_ff_idx", 32'(first_fail_idx), 32'd4);
    chk("single_ff_dut", 32'(first_fail_dut), 32'h00);
    chk("single_ff_ref", 32'(first_fail_ref), 32'h77);
    chk("single_pass", 32'(pass), 32'd0);

    // Mismatches at 2,3,10 with a start pulse during the run
    do_run(17'h0040C, 8'h3C, 8'hC3, 5, -1);
    chk("multi_fail_cnt", 32'(fail_cnt), 32'd3);
    chk("multi_ff_idx", 32'(first_fail_idx), 32'd2);
    chk("multi_ff_dut", 32'(first_fail_dut), 32'hC3);
    chk("multi_ff_ref", 32'(first_fail_ref), 32'h3C);

    // First and last sample differ in the top bit only
    do_run(17'h10001, 8'h00, 8'h80, -1, -1);
    chk("edge_fail_cnt", 32'(fail_cnt), 32'd2);
    chk("edge_ff_idx", 32'(first_fail_idx), 32'd0);
    chk("edge_ff_dut", 32'(first_fail_dut), 32'h80);
    chk("edge_ff_ref", 32'(first_fail_ref), 32'h00);

    // Reset at sample 6 after an earlier mismatch
    do_run(17'h00002, 8'h55, 8'h54, -1, 6);
    chk("post_abort_done", 32'(done), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_ff_dut", 32'(first_fail_dut), 32'd0);

    // Fresh run from IDLE with random data, mismatches at 1,3,9,11
    rv = 8'($urandom_range(0, 255));
    do_run(17'h00A0A, rv, rv ^ 8'h01, -1, -1);
    chk("rand_fail_cnt", 32'(fail_cnt), 32'd4);
    chk("rand_ff_idx", 32'(first_fail_idx), 32'd1);
    chk("rand_ff_dut", 32'(first_fail_dut), 32'(rv ^ 8'h01));
    chk("rand_ff_ref", 32'(first_fail_ref), 32'(rv));
    chk("rand_pass", 32'(pass), 32'd0);

    // Narrow counter instance: 3 samples, all unequal
    @(negedge clk);
    start2 = 1'b1; dut2 = 8'hAA; ref2 = 8'h55;
    @(negedge clk);
    start2 = 1'b0;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done2) break;
    end
    chk("sat_latency", 32'(i), 32'd2);
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_fail_cnt", 32'(fc2), 32'd3);
    chk("sat_ff_idx", 32'(ffi2), 32'd0);
    chk("sat_ff_dut", 32'(ffd2), 32'hAA);
    chk("sat_ff_ref", 32'(ffr2), 32'h55);
    chk("sat_pass", 32'(pass2), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
